// File: rtl/conv55_pkg.sv
// ---------------------------------------------------------------
// conv55_pkg : shared constants and FSM state encoding for conv55
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package conv55_pkg;

  localparam int ELEM_W = 6;
  localparam int TAPS   = 25;
  localparam int OUT_W  = 18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_K = 3'd1,
    ST_LOAD_D = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUT    = 3'd4
  } conv55_state_t;

endpackage

`default_nettype wire

// File: rtl/conv55_tap_buf.sv
// ---------------------------------------------------------------
// conv55_tap_buf : TAPS x ELEM_W register file, indexed write, flat read
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module conv55_tap_buf #(
  parameter int ELEM_W = 6,
  parameter int TAPS   = 25,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [ELEM_W-1:0]        wdata,
  output logic [TAPS*ELEM_W-1:0]   rdata
);

  genvar i;
  generate
    for (i = 0; i < TAPS; i++) begin : g_tap
      logic [ELEM_W-1:0] tap;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          tap <= '0;
        else if (we && (idx == IDX_W'(i)))
          tap <= wdata;
      end

      assign rdata[i*ELEM_W +: ELEM_W] = tap;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/conv55_sched.sv
// ---------------------------------------------------------------
// conv55_sched : kernel/window operand sequencer for the 5x5 PIM conv
// Optional handshake counter port enabled by CONV55_SCHED_PERF_EN. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module conv55_sched
  import conv55_pkg::*;
#(
  parameter int ELEM_W  = conv55_pkg::ELEM_W,
  parameter int TAPS    = conv55_pkg::TAPS,
  parameter int OUT_W   = conv55_pkg::OUT_W,
  parameter int PIM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kload_req,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ELEM_W-1:0]      s_data,
  output logic [TAPS*ELEM_W-1:0] pim_data,
  output logic [TAPS*ELEM_W-1:0] pim_kernel,
  input  logic [OUT_W-1:0]       pim_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_data,
`ifdef CONV55_SCHED_PERF_EN
  output logic [31:0]            perf_cnt,
`endif
  output logic                   busy,
  output logic                   kern_ok
);

  localparam int CNT_W  = $clog2(TAPS);
  localparam int WCNT_W = (PIM_LAT < 1) ? 1 : $clog2(PIM_LAT + 1);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_LOAD_K = 3'(ST_LOAD_K);
  localparam logic [2:0] S_LOAD_D = 3'(ST_LOAD_D);
  localparam logic [2:0] S_WAIT   = 3'(ST_WAIT);
  localparam logic [2:0] S_OUT    = 3'(ST_OUT);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [WCNT_W-1:0] wcnt;
  logic              hs;
  logic              last_tap;
  logic              k_we;
  logic              d_we;

  assign s_ready  = (state == S_LOAD_K) || (state == S_LOAD_D);
  assign m_valid  = (state == S_OUT);
  assign busy     = (state != S_IDLE);
  assign hs       = s_valid && s_ready;
  assign last_tap = (cnt == CNT_W'(TAPS - 1));
  assign k_we     = hs && (state == S_LOAD_K);
  assign d_we     = hs && (state == S_LOAD_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      kern_ok <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A kernel reload request wins over starting another window.
          if (kload_req) begin
            kern_ok <= 1'b0;
            cnt     <= '0;
            state   <= S_LOAD_K;
          end else if (kern_ok) begin
            cnt   <= '0;
            state <= S_LOAD_D;
          end
        end
        S_LOAD_K: begin
          if (hs) begin
            if (last_tap) begin
              cnt     <= '0;
              kern_ok <= 1'b1;
              state   <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_LOAD_D: begin
          if (hs) begin
            if (last_tap) begin
              cnt   <= '0;
              wcnt  <= '0;
              state <= S_WAIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (wcnt == WCNT_W'(PIM_LAT)) begin
            m_data <= pim_out;
            state  <= S_OUT;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        S_OUT: begin
          if (m_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV55_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_cnt <= '0;
    else if (m_valid && m_ready)
      perf_cnt <= perf_cnt + 32'd1;
  end
`endif

  conv55_tap_buf #(
    .ELEM_W (ELEM_W),
    .TAPS   (TAPS),
    .IDX_W  (CNT_W)
  ) u_kernel_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (k_we),
    .idx   (cnt),
    .wdata (s_data),
    .rdata (pim_kernel)
  );

  conv55_tap_buf #(
    .ELEM_W (ELEM_W),
    .TAPS   (TAPS),
    .IDX_W  (CNT_W)
  ) u_data_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (d_we),
    .idx   (cnt),
    .wdata (s_data),
    .rdata (pim_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_conv55_sched.sv
// ---------------------------------------------------------------
// tb_conv55_sched : directed self-checking bench for conv55_sched
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_conv55_sched;

  logic          clk;
  logic          rst_n;
  logic          kload_req;
  logic          s_valid;
  logic          s_ready;
  logic [5:0]    s_data;
  logic [149:0]  pim_data;
  logic [149:0]  pim_kernel;
  logic [17:0]   pim_out;
  logic          m_valid;
  logic          m_ready;
  logic [17:0]   m_data;
  logic          busy;
  logic          kern_ok;
`ifdef CONV55_SCHED_PERF_EN
  logic [31:0]   perf_cnt;
`endif

  int total = 0;
  int bad   = 0;

  conv55_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kload_req  (kload_req),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .pim_data   (pim_data),
    .pim_kernel (pim_kernel),
    .pim_out    (pim_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef CONV55_SCHED_PERF_EN
    .perf_cnt   (perf_cnt),
`endif
    .busy       (busy),
    .kern_ok    (kern_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout s_ready=%b required=1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_data  = 6'h00;
  endtask

  task automatic load_kernel(input int base, input int step);
    kload_req = 1'b1;
    tick();
    kload_req = 1'b0;
    for (int i = 0; i < 25; i++)
      send(6'(base + step * i));
  endtask

  // Edges from "now" (first cycle after the last handshake) until m_valid.
  task automatic wait_mvalid(output int edges);
    edges = 0;
    while (!m_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b1;
    tick();
    tick();
    total++;
    if ({s_ready, m_valid, busy, kern_ok} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b required=0000", {s_ready, m_valid, busy, kern_ok});
    end
    total++;
    if (m_data !== 18'h0) begin
      bad++;
      $display("FAIL reset_m_data got=%h required=0", m_data);
    end
    total++;
    if (pim_data !== 150'h0 || pim_kernel !== 150'h0) begin
      bad++;
      $display("FAIL reset_taps data=%h kernel=%h required=0", pim_data, pim_kernel);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (s_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_s_ready cyc=%0d got=%b required=0", i, s_ready);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_no_kernel();
    s_valid = 1'b1;
    kload_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if (s_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL no_kernel cyc=%0d s_ready=%b busy=%b required=0/0", i, s_ready, busy);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_full_pass();
    int edges;
    logic [149:0] all3f;
    all3f = {25{6'h3F}};
    kload_req = 1'b1;
    tick();
    kload_req = 1'b0;
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || kern_ok !== 1'b0) begin
      bad++;
      $display("FAIL load_k_entry busy=%b s_ready=%b kern_ok=%b required=1/1/0", busy, s_ready, kern_ok);
    end
    for (int i = 0; i < 25; i++)
      send(6'(i + 1));
    total++;
    if (kern_ok !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL kernel_done kern_ok=%b busy=%b required=1/0", kern_ok, busy);
    end
    total++;
    if (pim_kernel[24*6 +: 6] !== 6'd25 || pim_kernel[0 +: 6] !== 6'd1) begin
      bad++;
      $display("FAIL kernel_taps t24=%0d t0=%0d required=25/1", pim_kernel[24*6 +: 6], pim_kernel[0 +: 6]);
    end
    pim_out = 18'h00ABC;
    for (int i = 0; i < 25; i++)
      send(6'h3F);
    wait_mvalid(edges);
    total++;
    if (edges !== 2) begin
      bad++;
      $display("FAIL full_latency edges=%0d required=2", edges);
    end
    total++;
    if (m_data !== 18'h00ABC) begin
      bad++;
      $display("FAIL full_m_data got=%h required=00abc", m_data);
    end
    total++;
    if (pim_data !== all3f) begin
      bad++;
      $display("FAIL full_pim_data got=%h required=%h", pim_data, all3f);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_accept m_valid=%b required=0", m_valid);
    end
`ifdef CONV55_SCHED_PERF_EN
    total++;
    if (perf_cnt !== 32'd1) begin
      bad++;
      $display("FAIL perf_cnt got=%0d required=1", perf_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    int edges;
    pim_out = 18'h12345;
    for (int i = 0; i < 25; i++)
      send(6'(i));
    wait_mvalid(edges);
    total++;
    if (edges !== 2) begin
      bad++;
      $display("FAIL bp_latency edges=%0d required=2", edges);
    end
    total++;
    if (pim_data[5*6 +: 6] !== 6'd5 || pim_kernel[3*6 +: 6] !== 6'd4) begin
      bad++;
      $display("FAIL bp_taps d5=%0d k3=%0d required=5/4", pim_data[5*6 +: 6], pim_kernel[3*6 +: 6]);
    end
    pim_out = 18'h3FFFF;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== 18'h12345 || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d m_valid=%b m_data=%h s_ready=%b required=1/12345/0",
                 i, m_valid, m_data, s_ready);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_plus1 s_ready=%b required=0", s_ready);
    end
    tick();
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_plus2 s_ready=%b required=1", s_ready);
    end
  endtask

  task automatic test_bubbles();
    int edges;
    logic [5:0] v;
    pim_out = 18'h00777;
    for (int i = 0; i < 25; i++) begin
      s_valid = 1'b0;
      s_data  = 6'h2A;
      tick();
      send(6'((i * 7 + 3) % 64));
    end
    wait_mvalid(edges);
    total++;
    if (edges !== 2) begin
      bad++;
      $display("FAIL bubble_latency edges=%0d required=2", edges);
    end
    for (int i = 0; i < 25; i++) begin
      v = 6'((i * 7 + 3) % 64);
      total++;
      if (pim_data[i*6 +: 6] !== v) begin
        bad++;
        $display("FAIL bubble_tap%0d got=%h required=%h", i, pim_data[i*6 +: 6], v);
      end
    end
    total++;
    if (m_data !== 18'h00777) begin
      bad++;
      $display("FAIL bubble_m_data got=%h required=00777", m_data);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_abort();
    for (int i = 0; i < 12; i++)
      send(6'h15);
    rst_n = 1'b0;
    #1;
    total++;
    if (kern_ok !== 1'b0 || pim_kernel !== 150'h0) begin
      bad++;
      $display("FAIL abort_kernel kern_ok=%b pim_kernel=%h required=0/0", kern_ok, pim_kernel);
    end
    total++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || pim_data !== 150'h0) begin
      bad++;
      $display("FAIL abort_state busy=%b s_ready=%b pim_data=%h required=0/0/0", busy, s_ready, pim_data);
    end
    tick();
    rst_n = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (s_ready !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_ready cyc=%0d s_ready=%b required=0", i, s_ready);
      end
    end
    s_valid = 1'b0;
    load_kernel(25, -1);
    total++;
    if (kern_ok !== 1'b1 || pim_kernel[0 +: 6] !== 6'd25 || pim_kernel[24*6 +: 6] !== 6'd1) begin
      bad++;
      $display("FAIL abort_reload kern_ok=%b t0=%0d t24=%0d required=1/25/1",
               kern_ok, pim_kernel[0 +: 6], pim_kernel[24*6 +: 6]);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    kload_req = 1'b0;
    s_valid   = 1'b0;
    s_data    = 6'h00;
    pim_out   = 18'h0;
    m_ready   = 1'b0;
    test_reset();
    test_no_kernel();
    test_full_pass();
    test_backpressure();
    test_bubbles();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
